// File: rtl/spi_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_rx_fifo_pkg
// Brief   : Register map, status bit positions and bus FSM states for
//           the SPI receive FIFO.
// Revision: 1.0 - initial release
// ============================================================================
package spi_rx_fifo_pkg;

   localparam logic [31:0] WINDOW_SIZE = 32'h0000_0050;

   localparam logic [6:0] OFF_STATUS     = 7'h00;
   localparam logic [6:0] OFF_DATA0      = 7'h04;
   localparam logic [6:0] OFF_POP        = 7'h40;
   localparam logic [6:0] OFF_IRQ_ENABLE = 7'h44;
   localparam logic [6:0] OFF_IRQ_THRESH = 7'h48;
   localparam logic [6:0] OFF_CLEAR      = 7'h4C;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      BUS_IDLE     = 2'd0,
      BUS_RESP     = 2'd1,
      BUS_WAIT_LOW = 2'd2
   } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module  : spi_rx_fifo_mem
// Brief   : DEPTH x (32*BLOCK_WORDS) block storage with pointers, occupancy
//           count and word-select read port on the head entry.
// Revision: 1.0 - initial release
// ============================================================================
module spi_rx_fifo_mem
   import spi_rx_fifo_pkg::*;
#(
   parameter int BLOCK_WORDS = 4,
   parameter int DEPTH       = 4,
   parameter int CW          = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [32*BLOCK_WORDS-1:0] push_data,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [2:0]                rd_idx,
   output logic [31:0]               rd_word,
   output logic [CW-1:0]             count,
   output logic                      full,
   output logic                      empty
);

   localparam int PW = $clog2(DEPTH);

   logic [32*BLOCK_WORDS-1:0] storage [DEPTH];
   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             rd_ptr;
   logic                      do_push;
   logic                      do_pop;
   logic [32*BLOCK_WORDS-1:0] head;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Flush overrides everything; a pop frees the slot a full-FIFO push needs.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr] <= push_data;
   end

   assign head = storage[rd_ptr];

   always_comb begin
      rd_word = '0;
      if (!empty) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (rd_idx == 3'(i)) rd_word = head[32*i +: 32];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : spi_rx_fifo
// Brief   : Multi-entry SPI receive FIFO with memory-bus register window,
//           status, threshold/overflow interrupt and flush.
//           Option: SPI_RX_FIFO_AUTOPOP_EN - reading the last DATA word pops.
// Revision: 1.0 - initial release
// ============================================================================
module spi_rx_fifo
   import spi_rx_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          BLOCK_WORDS = 4,
   parameter int          DEPTH       = 4,
   parameter int          THRESH_RST  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [31:0]               mem_addr,
   input  logic [31:0]               mem_wdata,
   input  logic [3:0]                mem_wstrb,
   output logic [31:0]               mem_rdata,
   input  logic [32*BLOCK_WORDS-1:0] spi_rx_data,
   input  logic                      spi_rx_valid,
   output logic                      irq_rx
);

   localparam int CW = $clog2(DEPTH) + 1;

   bus_state_t    state;
   bus_state_t    state_next;
   logic [31:0]   offset;
   logic          in_window;
   logic [6:0]    reg_off;
   logic [4:0]    word_off;
   logic [4:0]    data_idx;
   logic          is_data;
   logic          req;
   logic          wr_req;
   logic          rd_req;
   logic [31:0]   rd_val;
   logic [31:0]   rdata_q;
   logic [1:0]    irq_en;
   logic [6:0]    thresh;
   logic          overflow;
   logic          pop_wr;
   logic          autopop;
   logic          pop;
   logic          flush;
   logic          clr_ovf;
   logic [31:0]   fifo_word;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          unused_bits;

   assign offset    = mem_addr - BASE_ADDR;
   assign in_window = (offset < WINDOW_SIZE);
   assign reg_off   = {offset[6:2], 2'b00};
   assign word_off  = offset[6:2];
   assign data_idx  = word_off - 5'd1;
   assign is_data   = (word_off != 5'd0) && (data_idx < 5'(BLOCK_WORDS));

   assign req    = (state == BUS_IDLE) && mem_valid && in_window;
   assign wr_req = req && (mem_wstrb != 4'b0000);
   assign rd_req = req && (mem_wstrb == 4'b0000);

   assign pop_wr  = wr_req && (reg_off == OFF_POP);
   assign flush   = wr_req && (reg_off == OFF_CLEAR) && mem_wdata[0];
   assign clr_ovf = wr_req && (reg_off == OFF_CLEAR) && mem_wdata[1];
`ifdef SPI_RX_FIFO_AUTOPOP_EN
   assign autopop = rd_req && is_data && (data_idx == 5'(BLOCK_WORDS - 1));
`else
   assign autopop = 1'b0;
`endif
   assign pop = pop_wr || autopop;

   spi_rx_fifo_mem #(
      .BLOCK_WORDS (BLOCK_WORDS),
      .DEPTH       (DEPTH),
      .CW          (CW)
   ) u_mem (
      .clk       (clk),
      .reset     (reset),
      .push      (spi_rx_valid),
      .push_data (spi_rx_data),
      .pop       (pop),
      .flush     (flush),
      .rd_idx    (data_idx[2:0]),
      .rd_word   (fifo_word),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      rd_val = '0;
      if (is_data) begin
         rd_val = fifo_word;
      end else begin
         case (reg_off)
            OFF_STATUS: begin
               rd_val[ST_NOT_EMPTY]             = !empty;
               rd_val[ST_FULL]                  = full;
               rd_val[ST_OVERFLOW]              = overflow;
               rd_val[ST_COUNT_LSB +: 8]        = 8'(count);
            end
            OFF_IRQ_ENABLE: rd_val[1:0] = irq_en;
            OFF_IRQ_THRESH: rd_val[6:0] = thresh;
            default:        rd_val      = '0;
         endcase
      end
   end

   // The responded state holds off a second response while the master
   // keeps mem_valid asserted past its ready pulse.
   always_comb begin
      state_next = state;
      mem_ready  = 1'b0;
      case (state)
         BUS_IDLE: if (req) state_next = BUS_RESP;
         BUS_RESP: begin
            mem_ready  = 1'b1;
            state_next = mem_valid ? BUS_WAIT_LOW : BUS_IDLE;
         end
         BUS_WAIT_LOW: if (!mem_valid) state_next = BUS_IDLE;
         default: state_next = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= BUS_IDLE;
         rdata_q  <= '0;
         irq_en   <= '0;
         thresh   <= 7'(THRESH_RST);
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         if (req) rdata_q <= rd_req ? rd_val : 32'h0;
         if (wr_req && reg_off == OFF_IRQ_ENABLE) irq_en <= mem_wdata[1:0];
         if (wr_req && reg_off == OFF_IRQ_THRESH)
            thresh <= (mem_wdata[6:0] == 7'd0) ? 7'd1 : mem_wdata[6:0];
         if (spi_rx_valid && full && !pop && !flush) overflow <= 1'b1;
         else if (clr_ovf)                            overflow <= 1'b0;
      end
   end

   assign mem_rdata = mem_ready ? rdata_q : 32'h0;
   assign irq_rx    = (irq_en[0] && (7'(count) >= thresh)) || (irq_en[1] && overflow);

   assign unused_bits = ^{mem_wdata[31:7], offset[1:0]};

endmodule
`default_nettype wire

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

Parametrised multi-entry receive FIFO between `spi_slave_8lane` and the PicoRV32 memory bus, replacing the single-block `spi_rx_buffer`. Each `spi_rx_valid` pulse pushes one `32*BLOCK_WORDS`-bit block. The CPU reads the head block word-by-word and pops it. Adds occupancy/full/sticky-overflow status, a programmable interrupt threshold, flush, and overflow interrupt.

## Interface
- `BASE_ADDR`, `32'h3000_0000`: base of the 0x50-byte register window.
- `BLOCK_WORDS`, 4: 32-bit words per block (1..8); 4 gives 128 bits.
- `DEPTH`, 4: entries; power of two, 2..64.
- `THRESH_RST`, 1: reset value of IRQ_THRESH.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: bus request.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: nonzero means write (byte lanes ignored, full word), zero means read.
- `mem_rdata` out 32: read data, valid while `mem_ready`=1, else 0.
- `spi_rx_data` in `32*BLOCK_WORDS`: block from SPI slave; byte 0 in bits [7:0].
- `spi_rx_valid` in 1: one-cycle push strobe.
- `irq_rx` out 1: level interrupt.

## Operation
- Register offsets:
  - 0x00 STATUS (RO): bit0 not_empty, bit1 full, bit2 overflow (sticky), [15:8] count.
  - 0x04+4i DATA_i (RO), i<BLOCK_WORDS: word i of head entry. Reads 0 when empty.
  - 0x40 POP (WO): any write pops the head. Ignored when empty.
  - 0x44 IRQ_ENABLE (RW): bit0 level irq, bit1 overflow irq. Reset 0.
  - 0x48 IRQ_THRESH (RW, [6:0]): writes of 0 store 1. Reset `THRESH_RST`.
  - 0x4C CLEAR (WO): bit0 flush (count←0, pointers←0), bit1 clear overflow.
  - Other in-window offsets: reads 0, writes ignored, `mem_ready` still pulses.
- Out-of-window addresses: block never asserts `mem_ready`. `mem_rdata` stays 0.
- Push: if not full, the block is stored at the write pointer and count increments. If full, the block is dropped, overflow is set, and the contents are unchanged.
- Simultaneous push and pop: both take effect and count is unchanged. A push when full plus a pop in the same cycle is accepted (no overflow).
- Flush in the same cycle as a push: flush wins and the push is discarded (no overflow).
- `irq_rx` = (en[0] & count≥thresh) | (en[1] & overflow). Combinational from registers, no extra delay.
- Pointers wrap modulo DEPTH. Count width is `$clog2(DEPTH)+1`.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `irq_rx`=0, count=0, pointers=0, overflow=0, IRQ_ENABLE=0, IRQ_THRESH=`THRESH_RST`. Stored data is not reset.
- Bus transaction:
  - `mem_valid` is sampled at edge N (in-window).
  - `mem_ready`=1 for exactly cycle N+1, with `mem_rdata` registered from state at edge N.
  - Writes take effect at edge N.
  - A responded flag blocks further responses until `mem_valid` is seen low. The master may hold `mem_valid` for a cycle after ready.
- Push latency: `spi_rx_valid` at edge N updates count/STATUS/`irq_rx` after edge N. A read sampled at N+1 sees the new count.
- Pop or clear at edge N: `irq_rx` drops after edge N if its condition no longer holds.
- Reset mid-transaction: `mem_ready` drops immediately and the responded flag clears.

## Configuration
- `SPI_RX_FIFO_AUTOPOP_EN` defined: a read of DATA_(BLOCK_WORDS-1) pops the head at the same edge it is sampled. The returned data is the pre-pop word. The POP register remains functional.
- Undefined: DATA reads have no side effects, and only POP/flush remove entries.

## Structure
- Package `spi_rx_fifo_pkg`: register offset localparams (STATUS, DATA0, POP, IRQ_ENABLE, IRQ_THRESH, CLEAR), STATUS bit positions, window size 0x50.
- Sub-module `spi_rx_fifo_mem`: `DEPTH`×`32*BLOCK_WORDS` storage with wr/rd pointers, push/pop/flush, count, full/empty. Word select by read index. The top level holds the bus FSM (IDLE/RESP/WAIT_LOW), registers and irq.

## Test plan
- Reset, read 0x3000_0000 → 0x0000_0000. Read 0x3000_0048 → 0x0000_0001. `irq_rx`=0.
- Send ciphertext 5a c5 b4 70 80 b7 cd d8 30 04 7b 6a d8 e0 c4 69 via the SPI slave.
  - STATUS → 0x0000_0101.
  - DATA_0..3 → 0x70b4c55a, 0xd8cdb780, 0x6a7b0430, 0x69c4e0d8.
  - Write POP → STATUS 0x0.
- IRQ_ENABLE=1, IRQ_THRESH=3: push 2 blocks → `irq_rx`=0. Push a 3rd → `irq_rx`=1. POP → `irq_rx`=0.
- Push 5 blocks with DEPTH=4: STATUS → 0x0000_0407, head is block 1 (byte0 of block 5 absent). Write CLEAR=2 → 0x0000_0403. Write CLEAR=1 → 0x0.
- Hold `mem_valid` 3 cycles on a POP write with 2 entries → `mem_ready` pulses once, count becomes 1. Address 0x4000_0000 → no `mem_ready`.
- With `SPI_RX_FIFO_AUTOPOP_EN`: 2 blocks, read DATA_3 → first block's word 3 returned, STATUS count=1. Without the macro, count remains 2.
